// File: rtl/fighter_anim_ctrl.sv
// Fighter animation sequencer and sprite ROM address generator.
// Picks the pose ROM (stand / crouch / punch / crouch-punch) and steps
// attack poses through windup, active and recovery phases counted in frames.
// It also turns the current DrawX/DrawY into a local ROM address for a
// SPRITE_DIM x SPRITE_DIM sprite placed at (pos_x, pos_y). The sprite can be
// mirrored horizontally.
module fighter_anim_ctrl #(
  parameter int SPRITE_DIM     = 64,
  parameter int ADDR_W         = 12,
  parameter int WINDUP_FRAMES  = 3,
  parameter int ACTIVE_FRAMES  = 4,
  parameter int RECOVER_FRAMES = 5
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              frame_tick,
  input  logic              btn_punch,
  input  logic              btn_crouch,
  input  logic              facing_left,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [1:0]        sprite_sel,
  output logic [ADDR_W-1:0] rom_address,
  output logic              sprite_on,
  output logic              hit_active,
  output logic              busy
);

  localparam int REL_W = $clog2(SPRITE_DIM);
  localparam int CNT_W = 8;

  localparam logic [CNT_W-1:0] WIND_LD = CNT_W'(WINDUP_FRAMES - 1);
  localparam logic [CNT_W-1:0] ACT_LD  = CNT_W'(ACTIVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] REC_LD  = CNT_W'(RECOVER_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic signed [11:0] DIM_S   = 12'(SPRITE_DIM);
  localparam logic [REL_W-1:0]   MAX_COL = '1;

  typedef enum logic [2:0] {
    STAND   = 3'd0,
    CROUCH  = 3'd1,
    P_WIND  = 3'd2,
    P_ACT   = 3'd3,
    P_REC   = 3'd4,
    CP_WIND = 3'd5,
    CP_ACT  = 3'd6,
    CP_REC  = 3'd7
  } state_t;

  // Signed distance of a draw coordinate from the box origin. The
  // difference is taken 12-bit signed, so boxes that extend past the screen
  // edge or past 1023 never wrap back into view.
  function automatic logic in_span(input logic [9:0] draw, input logic [9:0] org);
    logic signed [11:0] d;
    d = signed'({2'b00, draw}) - signed'({2'b00, org});
    return (d >= 12'sd0) && (d < DIM_S);
  endfunction

  // Column inside the sprite. When mirrored, the column counts from the far edge.
  function automatic logic [REL_W-1:0] mirror_col(input logic [REL_W-1:0] rel,
                                                  input logic             mirror);
    return mirror ? (MAX_COL - rel) : rel;
  endfunction

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             facing_q, facing_d;
  logic             btn_punch_d;
  logic             punch_pending;
  logic             punch_rise;
  logic             punch_take;
  logic [1:0]       sel_d;
  logic             busy_d;
  logic             hit_d;

  // A punch edge in the tick cycle itself still counts for that tick.
  assign punch_rise = btn_punch & ~btn_punch_d;
  assign punch_take = punch_pending | punch_rise;

  // Latch punch edges between frame ticks. The pending flag is used or dropped at every tick.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_punch_d   <= 1'b0;
      punch_pending <= 1'b0;
    end else begin
      btn_punch_d <= btn_punch;
      if (frame_tick)
        punch_pending <= 1'b0;
      else if (punch_rise)
        punch_pending <= 1'b1;
    end
  end

  // Pose state, phase counter, facing and decoded outputs advance only on frame ticks.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= STAND;
      cnt        <= '0;
      facing_q   <= 1'b0;
      sprite_sel <= 2'd0;
      busy       <= 1'b0;
      hit_active <= 1'b0;
    end else if (frame_tick) begin
      state      <= state_d;
      cnt        <= cnt_d;
      facing_q   <= facing_d;
      sprite_sel <= sel_d;
      busy       <= busy_d;
      hit_active <= hit_d;
    end
  end

  // Next pose and phase count, plus output decode of the next pose.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      STAND: begin
        if (punch_take && btn_crouch) begin
          state_d = CP_WIND;
          cnt_d   = WIND_LD;
        end else if (punch_take) begin
          state_d = P_WIND;
          cnt_d   = WIND_LD;
        end else if (btn_crouch) begin
          state_d = CROUCH;
        end
      end
      CROUCH: begin
        if (punch_take) begin
          state_d = CP_WIND;
          cnt_d   = WIND_LD;
        end else if (!btn_crouch) begin
          state_d = STAND;
        end
      end
      P_WIND, CP_WIND: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_ONE;
        end else begin
          state_d = (state == P_WIND) ? P_ACT : CP_ACT;
          cnt_d   = ACT_LD;
        end
      end
      P_ACT, CP_ACT: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_ONE;
        end else begin
          state_d = (state == P_ACT) ? P_REC : CP_REC;
          cnt_d   = REC_LD;
        end
      end
      P_REC, CP_REC: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_ONE;
        end else begin
          state_d = btn_crouch ? CROUCH : STAND;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = STAND;
        cnt_d   = '0;
      end
    endcase

    sel_d  = 2'd0;
    busy_d = 1'b0;
    hit_d  = 1'b0;
    unique case (state_d)
      STAND:                    sel_d = 2'd0;
      CROUCH:                   sel_d = 2'd1;
      P_WIND, P_ACT, P_REC:     sel_d = 2'd2;
      CP_WIND, CP_ACT, CP_REC:  sel_d = 2'd3;
      default:                  sel_d = 2'd0;
    endcase
    busy_d = (state_d != STAND) && (state_d != CROUCH);
    hit_d  = (state_d == P_ACT) || (state_d == CP_ACT);

    // Facing is frozen for the whole attack. It is only re-read on ticks that land idle.
    facing_d = busy_d ? facing_q : facing_left;
  end

  // ---- stage p0: box test and local coordinates from the live draw position
  logic              inside_p0;
  logic [REL_W-1:0]  rel_x_p0;
  logic [REL_W-1:0]  rel_y_p0;
  logic [REL_W-1:0]  col_p0;
  logic [ADDR_W-1:0] addr_p0;

  assign inside_p0 = in_span(DrawX, pos_x) && in_span(DrawY, pos_y);
  assign rel_x_p0  = REL_W'(DrawX - pos_x);
  assign rel_y_p0  = REL_W'(DrawY - pos_y);
  assign col_p0    = mirror_col(rel_x_p0, facing_q);
  assign addr_p0   = ADDR_W'({rel_y_p0, col_p0});

  // ---- stage p1: registered ROM address and in-box flag
  logic [ADDR_W-1:0] rom_addr_p1;
  logic              sprite_on_p1;

  // Address path runs every pixel clock, regardless of frame ticks.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_p1  <= '0;
      sprite_on_p1 <= 1'b0;
    end else begin
      rom_addr_p1  <= inside_p0 ? addr_p0 : '0;
      sprite_on_p1 <= inside_p0;
    end
  end

  assign rom_address = rom_addr_p1;
  assign sprite_on   = sprite_on_p1;

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Scoreboard bench for fighter_anim_ctrl. Stimulus is driven on falling edges,
// and expected values are queued at the same moment. A monitor pops the
// queue and compares one time unit after each rising edge.
module tb_fighter_anim_ctrl;

  localparam int W = 3;
  localparam int A = 4;
  localparam int R = 5;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic        btn_punch;
  logic        btn_crouch;
  logic        facing_left;
  logic [9:0]  pos_x, pos_y, DrawX, DrawY;
  logic [1:0]  sprite_sel;
  logic [11:0] rom_address;
  logic        sprite_on;
  logic        hit_active;
  logic        busy;

  fighter_anim_ctrl dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .btn_punch   (btn_punch),
    .btn_crouch  (btn_crouch),
    .facing_left (facing_left),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .sprite_sel  (sprite_sel),
    .rom_address (rom_address),
    .sprite_on   (sprite_on),
    .hit_active  (hit_active),
    .busy        (busy)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    string       tag;
    int          kind;   // 0 = pixel {sprite_on, rom_address}, 1 = pose {sel, busy, hit}
    logic [15:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  // Reference model state
  int   m_t    = 0;      // frames into current attack, 0 = idle
  logic m_cp   = 1'b0;   // attack started crouched
  logic m_pend = 1'b0;
  logic m_face = 1'b0;
  logic [1:0] m_sel = 2'd0;
  logic m_busy = 1'b0;
  logic m_hit  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge vga_clk) begin
    #1;
    while (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      if (e.kind == 0) check_eq(e.tag, 32'({sprite_on, rom_address}), 32'(e.exp));
      else             check_eq(e.tag, 32'({sprite_sel, busy, hit_active}), 32'(e.exp));
    end
  end

  task automatic model_tick();
    if (m_t > 0) begin
      m_t++;
      if (m_t > W + A + R) m_t = 0;
    end else if (m_pend) begin
      m_t  = 1;
      m_cp = btn_crouch;
    end
    m_pend = 1'b0;
    if (m_t == 0) begin
      m_sel  = btn_crouch ? 2'd1 : 2'd0;
      m_busy = 1'b0;
      m_hit  = 1'b0;
      m_face = facing_left;
    end else begin
      m_sel  = m_cp ? 2'd3 : 2'd2;
      m_busy = 1'b1;
      m_hit  = (m_t > W) && (m_t <= W + A);
    end
  endtask

  function automatic logic [15:0] pix_exp(input int dx, input int dy);
    int px, py, rx, ry, col;
    px = int'(pos_x);
    py = int'(pos_y);
    if (dx >= px && dx < px + 64 && dy >= py && dy < py + 64) begin
      rx  = dx - px;
      ry  = dy - py;
      col = m_face ? (63 - rx) : rx;
      return {3'b000, 1'b1, 12'(ry * 64 + col)};
    end
    return 16'h0000;
  endfunction

  // pv: -1 leaves btn_punch alone, otherwise drives it in the tick cycle
  task automatic do_tick(input string tag, input int pv);
    sb_t e;
    @(negedge vga_clk);
    if (pv >= 0) begin
      if (pv != 0 && btn_punch == 1'b0) m_pend = 1'b1;
      btn_punch = (pv != 0);
    end
    frame_tick = 1'b1;
    model_tick();
    e.tag = tag; e.kind = 1; e.exp = {13'b0, m_sel, m_busy, m_hit};
    sb.push_back(e);
    @(negedge vga_clk);
    frame_tick = 1'b0;
  endtask

  task automatic pix(input string tag, input int dx, input int dy);
    sb_t e;
    @(negedge vga_clk);
    DrawX = 10'(dx);
    DrawY = 10'(dy);
    e.tag = tag; e.kind = 0; e.exp = pix_exp(dx, dy);
    sb.push_back(e);
  endtask

  task automatic press();
    @(negedge vga_clk);
    if (btn_punch == 1'b0) m_pend = 1'b1;
    btn_punch = 1'b1;
    @(negedge vga_clk);
    btn_punch = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0; btn_punch = 1'b0; btn_crouch = 1'b0;
    facing_left = 1'b0; pos_x = 10'd100; pos_y = 10'd50; DrawX = 10'd0; DrawY = 10'd0;
    repeat (2) @(negedge vga_clk);
    check_eq("rst_sel",  32'(sprite_sel), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_hit",  32'(hit_active), 32'd0);
    check_eq("rst_addr", 32'(rom_address), 32'd0);
    check_eq("rst_on",   32'(sprite_on), 32'd0);
    @(negedge vga_clk);
    reset_n = 1'b1;

    do_tick("idle", -1);

    // Address path, unmirrored
    pix("pix_origin", 100, 50);
    pix("pix_corner", 163, 113);
    pix("pix_right_out", 164, 50);
    pix("pix_left_out", 99, 50);
    pix("pix_below_out", 100, 114);
    pix("pix_mid", 110, 60);

    // Standing punch with a retrigger attempt and a facing change mid-attack
    press();
    for (int i = 1; i <= 13; i++) begin
      if (i == 2) begin
        facing_left = 1'b1;
        pix("pix_frozen_face", 100, 50);
      end
      if (i == 6) press();
      do_tick($sformatf("punch_t%0d", i), -1);
    end
    pix("pix_mirror_row1", 100, 51);
    pix("pix_mirror_row0", 100, 50);

    // Crouch punch, crouch held through recovery
    btn_crouch = 1'b1;
    do_tick("crouch", -1);
    press();
    for (int i = 1; i <= 13; i++) do_tick($sformatf("cpunch_t%0d", i), -1);
    btn_crouch = 1'b0;
    do_tick("uncrouch", -1);

    // Punch edge on the tick itself, then held high: exactly one attack
    do_tick("held_t1", 1);
    for (int i = 2; i <= 15; i++) do_tick($sformatf("held_t%0d", i), -1);
    do_tick("held_release", 0);

    // Reset in the middle of the active phase
    press();
    for (int i = 1; i <= 5; i++) do_tick($sformatf("pre_rst_t%0d", i), -1);
    pix("pix_pre_rst", 100, 51);
    @(negedge vga_clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_sel",  32'(sprite_sel), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_hit",  32'(hit_active), 32'd0);
    check_eq("mid_rst_addr", 32'(rom_address), 32'd0);
    check_eq("mid_rst_on",   32'(sprite_on), 32'd0);
    repeat (2) @(negedge vga_clk);
    reset_n = 1'b1;
    m_t = 0; m_pend = 1'b0; m_face = 1'b0; m_sel = 2'd0; m_busy = 1'b0; m_hit = 1'b0;
    pix("pix_post_rst_face0", 100, 51);
    do_tick("post_rst_tick", -1);
    pix("pix_post_rst_face1", 100, 51);

    // Screen-edge and wrap boundaries, unmirrored
    facing_left = 1'b0;
    do_tick("face_right", -1);
    pos_x = 10'd600; pos_y = 10'd400;
    pix("pix_x639", 639, 400);
    pix("pix_x639_bot", 639, 463);
    pix("pix_x599_out", 599, 400);
    pos_x = 10'd1000; pos_y = 10'd0;
    pix("pix_x1023", 1023, 0);
    pix("pix_nowrap", 5, 0);
    pos_x = 10'd0; pos_y = 10'd1000;
    pix("pix_y1023", 0, 1023);
    pix("pix_ynowrap", 0, 10);

    @(negedge vga_clk);
    @(negedge vga_clk);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
